// File: rtl/spi_master_periph.sv
// spi_master_periph
//   APB slave that turns TXD register writes into single-byte SPI master
//   transfers (modes 0-3, MSB first) and returns the received byte via RXD.
//
//   Ports
//     PCLK, PRESET          clock, synchronous active-high reset
//     PADDR/PWDATA/PWRITE/  APB slave side; only PADDR[3:2] is decoded,
//     PENABLE/PSEL          zero-wait (PREADY = PSEL & PENABLE)
//     PRDATA, PREADY        read data (0 unless a read access phase), ready
//     sclk, mosi, miso      SPI bus
//     cs_n                  chip select, low for the whole transfer
//
//   Register map: 0x0 CR {CLKDIV[15:8], CPHA[2], CPOL[1], EN[0]},
//   0x4 TXD (write-only), 0x8 RXD (read clears RXNE),
//   0xC SR {OVR[3], WCOL[2], RXNE[1], BUSY[0]} (write 1 clears WCOL/OVR).
module spi_master_periph #(
  parameter logic [7:0] CLKDIV_RST = 8'd4
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_e;
  state_e state_q, state_d;

  logic       cr_en_q, cr_en_d, cr_cpol_q, cr_cpol_d, cr_cpha_q, cr_cpha_d;
  logic [7:0] cr_div_q, cr_div_d;
  logic [7:0] rxd_q, rxd_d;
  logic       rxne_q, rxne_d, wcol_q, wcol_d, ovr_q, ovr_d;
  // Transfer parameters frozen at TXD accept so CR writes only affect the next byte.
  logic       cpol_q, cpol_d, cpha_q, cpha_d;
  logic [7:0] div_q, div_d;
  logic [7:0] shift_q, shift_d;
  logic       rxbit_q, rxbit_d, mosi_q, mosi_d, sclk_q, sclk_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] edge_q, edge_d;

  logic acc, wr, rd, cr_wr, txd_wr, sr_wr, rxd_rd;
  logic busy, tick, abort, accept, done, leading, trailing;
  logic unused_bits;

  assign acc      = PSEL & PENABLE;
  assign wr       = acc & PWRITE;
  assign rd       = acc & ~PWRITE;
  assign cr_wr    = wr & (PADDR[3:2] == 2'd0);
  assign txd_wr   = wr & (PADDR[3:2] == 2'd1);
  assign sr_wr    = wr & (PADDR[3:2] == 2'd3);
  assign rxd_rd   = rd & (PADDR[3:2] == 2'd2);
  assign busy     = (state_q != IDLE);
  assign tick     = (cnt_q == div_q);
  assign abort    = busy & cr_wr & ~PWDATA[0];
  assign accept   = txd_wr & cr_en_q & ~busy;
  assign done     = (state_q == TRAIL) & tick & ~abort;
  // edge_q counts completed edges, so an even count means the next edge is leading.
  assign leading  = (state_q == XFER) & tick & ~edge_q[0];
  assign trailing = (state_q == XFER) & tick & edge_q[0];

  assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LEAD;
      LEAD:    if (tick) state_d = XFER;
      XFER:    if (tick && edge_q == 4'd15) state_d = TRAIL;
      TRAIL:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    cr_en_d   = cr_en_q;
    cr_cpol_d = cr_cpol_q;
    cr_cpha_d = cr_cpha_q;
    cr_div_d  = cr_div_q;
    rxd_d     = rxd_q;
    rxne_d    = rxne_q;
    wcol_d    = wcol_q;
    ovr_d     = ovr_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    div_d     = div_q;
    shift_d   = shift_q;
    rxbit_d   = rxbit_q;
    mosi_d    = mosi_q;
    sclk_d    = sclk_q;

    if (cr_wr) begin
      cr_en_d   = PWDATA[0];
      cr_cpol_d = PWDATA[1];
      cr_cpha_d = PWDATA[2];
      cr_div_d  = PWDATA[15:8];
    end

    if (accept) begin
      cpol_d  = cr_cpol_q;
      cpha_d  = cr_cpha_q;
      div_d   = cr_div_q;
      shift_d = PWDATA[7:0];
      mosi_d  = PWDATA[7];
      sclk_d  = cr_cpol_q;
    end

    if (leading || trailing) sclk_d = ~sclk_q;

    if (leading) begin
      if (cpha_q) mosi_d = shift_q[7];
      else        rxbit_d = miso;
    end

    if (trailing) begin
      if (cpha_q) begin
        shift_d = {shift_q[6:0], miso};
      end else begin
        shift_d = {shift_q[6:0], rxbit_q};
        mosi_d  = shift_q[6];
      end
    end

    // Divider restarts on every state change so each phase gets full half-periods.
    if (state_q == IDLE || state_d != state_q || tick) cnt_d = '0;
    else                                               cnt_d = cnt_q + 8'd1;

    if (state_q != XFER) edge_d = '0;
    else if (tick)       edge_d = edge_q + 4'd1;
    else                 edge_d = edge_q;

    // Clears first, then sets: a coincident set event wins.
    if (rxd_rd)                  rxne_d = 1'b0;
    if (sr_wr && PWDATA[2])      wcol_d = 1'b0;
    if (sr_wr && PWDATA[3])      ovr_d  = 1'b0;
    if (txd_wr && cr_en_q && busy) wcol_d = 1'b1;
    if (done) begin
      rxd_d  = shift_q;
      rxne_d = 1'b1;
      // A read landing on the completion edge consumed the old byte: no overrun.
      if (rxne_q && !rxd_rd) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cr_en_q   <= 1'b0;
      cr_cpol_q <= 1'b0;
      cr_cpha_q <= 1'b0;
      cr_div_q  <= CLKDIV_RST;
      rxd_q     <= '0;
      rxne_q    <= 1'b0;
      wcol_q    <= 1'b0;
      ovr_q     <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      div_q     <= '0;
      shift_q   <= '0;
      rxbit_q   <= 1'b0;
      mosi_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cnt_q     <= '0;
      edge_q    <= '0;
    end else begin
      state_q   <= state_d;
      cr_en_q   <= cr_en_d;
      cr_cpol_q <= cr_cpol_d;
      cr_cpha_q <= cr_cpha_d;
      cr_div_q  <= cr_div_d;
      rxd_q     <= rxd_d;
      rxne_q    <= rxne_d;
      wcol_q    <= wcol_d;
      ovr_q     <= ovr_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      div_q     <= div_d;
      shift_q   <= shift_d;
      rxbit_q   <= rxbit_d;
      mosi_q    <= mosi_d;
      sclk_q    <= sclk_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (rd) begin
      unique case (PADDR[3:2])
        2'd0:    PRDATA = {16'h0, cr_div_q, 5'h0, cr_cpha_q, cr_cpol_q, cr_en_q};
        2'd2:    PRDATA = {24'h0, rxd_q};
        2'd3:    PRDATA = {28'h0, ovr_q, wcol_q, rxne_q, busy};
        default: PRDATA = '0;
      endcase
    end
  end

  assign PREADY = acc;
  assign cs_n   = (state_q == IDLE);
  assign sclk   = (state_q == IDLE) ? cr_cpol_q : sclk_q;
  assign mosi   = mosi_q;

endmodule
